// File: rtl/lane_overlay.sv
// lane_overlay
// Streams one image frame out of a BRAM in raster order and paints the pixels
// that lie on either of two lane lines (Hough form: x*cos + y*sin = rho) with
// LANE_COLOR. The signed line distance is tracked incrementally with adders
// only. Pixels are read from the BRAM in READ and emitted in WRITE, giving one
// pixel every two cycles when the output FIFO is not full.
//
// Ports
//   clock, reset        single clock, synchronous active-low reset
//   start               begin a frame (sampled only in IDLE)
//   left_/right_rho     line distance in pixels (signed 16)
//   left_/right_cos/sin line normal in Q2.14 (16384 = 1.0)
//   bram_rd_addr        BRAM read address, data returns one cycle later
//   bram_rd_data        RGB pixel from the BRAM
//   out_wr_en, out_din  output FIFO write strobe and annotated pixel
//   out_full            output FIFO full
//   busy, done          frame in progress / one-cycle frame-complete pulse
//   dbg_state           current FSM state, for observation only
module lane_overlay #(
  parameter int          WIDTH       = 720,
  parameter int          HEIGHT      = 540,
  parameter int          IMAGE_SIZE  = WIDTH * HEIGHT,
  parameter int          THICKNESS   = 2,
  parameter int          HORIZON_ROW = 0,
  parameter logic [23:0] LANE_COLOR  = 24'hFF0000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [15:0]            left_rho,
  input  logic signed [15:0]            right_rho,
  input  logic signed [15:0]            left_cos,
  input  logic signed [15:0]            left_sin,
  input  logic signed [15:0]            right_cos,
  input  logic signed [15:0]            right_sin,
  output logic [$clog2(IMAGE_SIZE)-1:0] bram_rd_addr,
  input  logic [23:0]                   bram_rd_data,
  output logic                          out_wr_en,
  input  logic                          out_full,
  output logic [23:0]                   out_din,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    dbg_state
);

  localparam int AW = $clog2(IMAGE_SIZE);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  // Half-width of a line expressed in the Q.14 distance domain.
  localparam logic signed [31:0] THICK_Q = 32'(THICKNESS) <<< 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic [AW-1:0]        addr_q;
  logic signed [31:0]   acc_l_q, acc_r_q;   // distance of current pixel to line
  logic signed [31:0]   row_l_q, row_r_q;   // distance of column 0 of current row
  logic signed [15:0]   cos_l_q, sin_l_q, cos_r_q, sin_r_q;

  logic signed [31:0]   rho_l_ext, rho_r_ext;
  logic signed [31:0]   cos_l_ext, sin_l_ext, cos_r_ext, sin_r_ext;
  logic                 hit_l, hit_r, above_horizon;
  logic [23:0]          pix;

  assign rho_l_ext = {{16{left_rho[15]}},  left_rho};
  assign rho_r_ext = {{16{right_rho[15]}}, right_rho};
  assign cos_l_ext = {{16{cos_l_q[15]}}, cos_l_q};
  assign sin_l_ext = {{16{sin_l_q[15]}}, sin_l_q};
  assign cos_r_ext = {{16{cos_r_q[15]}}, cos_r_q};
  assign sin_r_ext = {{16{sin_r_q[15]}}, sin_r_q};

  assign hit_l         = (acc_l_q >= -THICK_Q) && (acc_l_q <= THICK_Q);
  assign hit_r         = (acc_r_q >= -THICK_Q) && (acc_r_q <= THICK_Q);
  assign above_horizon = int'(y_q) >= HORIZON_ROW;
  assign pix           = ((hit_l || hit_r) && above_horizon) ? LANE_COLOR : bram_rd_data;

  // Output handshake: a pixel is transferred on every clock edge where
  // out_wr_en = 1. out_wr_en is raised only in WRITE while out_full = 0; with
  // out_full = 1 the FSM waits in WRITE with address, data and position frozen,
  // so each pixel is written exactly once.
  assign out_wr_en    = (state_q == S_WRITE) && !out_full;
  assign out_din      = (state_q == S_WRITE) ? pix : 24'h0;
  assign bram_rd_addr = addr_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign dbg_state    = state_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      row_l_q <= '0;
      row_r_q <= '0;
      cos_l_q <= '0;
      sin_l_q <= '0;
      cos_r_q <= '0;
      sin_r_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_INIT;
        end
        S_INIT: begin
          cos_l_q <= left_cos;
          sin_l_q <= left_sin;
          cos_r_q <= right_cos;
          sin_r_q <= right_sin;
          x_q     <= '0;
          y_q     <= '0;
          addr_q  <= '0;
          // Pixel (0,0) sits at distance -rho from each line.
          acc_l_q <= -(rho_l_ext <<< 14);
          row_l_q <= -(rho_l_ext <<< 14);
          acc_r_q <= -(rho_r_ext <<< 14);
          row_r_q <= -(rho_r_ext <<< 14);
          state_q <= S_READ;
        end
        S_READ: begin
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (!out_full) begin
            if (x_q != X_LAST) begin
              x_q     <= x_q + XW'(1);
              addr_q  <= addr_q + AW'(1);
              acc_l_q <= acc_l_q + cos_l_ext;
              acc_r_q <= acc_r_q + cos_r_ext;
              state_q <= S_READ;
            end else if (y_q != Y_LAST) begin
              // Next row restarts from the row base, stepped by sin.
              x_q     <= '0;
              y_q     <= y_q + YW'(1);
              addr_q  <= addr_q + AW'(1);
              row_l_q <= row_l_q + sin_l_ext;
              acc_l_q <= row_l_q + sin_l_ext;
              row_r_q <= row_r_q + sin_r_ext;
              acc_r_q <= row_r_q + sin_r_ext;
              state_q <= S_READ;
            end else begin
              // Last pixel: the address is left in place rather than wrapped.
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_overlay.sv
// Bench for lane_overlay: 8x4 image, zero line thickness, BRAM content equal
// to the address. Two instances differ only in HORIZON_ROW (0 and 3); sel
// chooses which one is started and watched.
module tb_lane_overlay;

  localparam int          W  = 8;
  localparam int          H  = 4;
  localparam int          N  = W * H;
  localparam int          AW = $clog2(N);
  localparam int          T  = 0;
  localparam logic [23:0] LC = 24'hFF0000;

  // ---------------- clock / reset / signals ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, start, out_full, sel;
  logic signed [15:0] l_rho, l_cos, l_sin, r_rho, r_cos, r_sin;
  logic start0, start3;
  logic [AW-1:0] addr0, addr3;
  logic [23:0] rd0, rd3, din0, din3;
  logic wr0, wr3, busy0, busy3, done0, done3;
  logic [2:0] st0, st3;

  assign start0 = start & ~sel;
  assign start3 = start & sel;

  lane_overlay #(.WIDTH(W), .HEIGHT(H), .THICKNESS(T), .HORIZON_ROW(0), .LANE_COLOR(LC)) u_dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .left_rho(l_rho), .right_rho(r_rho),
    .left_cos(l_cos), .left_sin(l_sin), .right_cos(r_cos), .right_sin(r_sin),
    .bram_rd_addr(addr0), .bram_rd_data(rd0),
    .out_wr_en(wr0), .out_full(out_full), .out_din(din0),
    .busy(busy0), .done(done0), .dbg_state(st0)
  );

  lane_overlay #(.WIDTH(W), .HEIGHT(H), .THICKNESS(T), .HORIZON_ROW(3), .LANE_COLOR(LC)) u_dut3 (
    .clock(clock), .reset(reset), .start(start3),
    .left_rho(l_rho), .right_rho(r_rho),
    .left_cos(l_cos), .left_sin(l_sin), .right_cos(r_cos), .right_sin(r_sin),
    .bram_rd_addr(addr3), .bram_rd_data(rd3),
    .out_wr_en(wr3), .out_full(out_full), .out_din(din3),
    .busy(busy3), .done(done3), .dbg_state(st3)
  );

  // BRAM models: one-cycle read latency, content = address.
  always @(posedge clock) begin
    rd0 <= 24'(addr0);
    rd3 <= 24'(addr3);
  end

  logic m_wr, m_busy, m_done, other_wr;
  logic [23:0] m_din;
  logic [AW-1:0] m_addr;
  assign m_wr     = sel ? wr3   : wr0;
  assign m_busy   = sel ? busy3 : busy0;
  assign m_done   = sel ? done3 : done0;
  assign m_din    = sel ? din3  : din0;
  assign m_addr   = sel ? addr3 : addr0;
  assign other_wr = sel ? wr0   : wr3;

  // ---------------- scoreboard ----------------
  logic [23:0]   exp_q[$];
  logic [AW-1:0] exp_a_q[$];
  int checks = 0;
  int passes = 0;
  int wr_count = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference: signed distance of pixel (x,y) to each line, straight from
  // x*cos + y*sin - rho, compared with the line half-width.
  function automatic logic [23:0] model_pix(input int idx, input int lr, input int lc, input int ls,
                                            input int rr, input int rc, input int rs, input int hor);
    int x, y;
    longint dl, dr;
    bit hit;
    x  = idx % W;
    y  = idx / W;
    dl = longint'(x) * lc + longint'(y) * ls - longint'(lr) * 16384;
    dr = longint'(x) * rc + longint'(y) * rs - longint'(rr) * 16384;
    hit = (dl >= -T * 16384 && dl <= T * 16384) || (dr >= -T * 16384 && dr <= T * 16384);
    return (hit && y >= hor) ? LC : 24'(idx);
  endfunction

  // Monitor: pops an expected pixel on every write.
  always @(negedge clock) begin
    if (m_wr) begin
      wr_count++;
      if (exp_q.size() == 0) check("unexpected_write", 32'(m_addr), 32'hFFFF_FFFF);
      else begin
        check("pixel", 32'(m_din), 32'(exp_q.pop_front()));
        check("write_addr", 32'(m_addr), 32'(exp_a_q.pop_front()));
      end
    end
    if (other_wr) check("idle_instance_write", 32'(1), 32'(0));
    if (m_done) begin
      done_count++;
      check("done_after_last_write", 32'(exp_q.size()), 32'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int lr, input int lc, input int ls,
                            input int rr, input int rc, input int rs, input int hor);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(model_pix(i, lr, lc, ls, rr, rc, rs, hor));
      exp_a_q.push_back(AW'(i));
    end
  endtask

  // Pulses start with the given lanes, checks the INIT/READ/first-WRITE timing
  // and scrambles the lane inputs once they have been captured.
  task automatic launch(input int lr, input int lc, input int ls,
                        input int rr, input int rc, input int rs, input bit hsel);
    sel = hsel;
    wr_count = 0;
    push_frame(lr, lc, ls, rr, rc, rs, hsel ? 3 : 0);
    @(negedge clock);
    l_rho = 16'(lr); l_cos = 16'(lc); l_sin = 16'(ls);
    r_rho = 16'(rr); r_cos = 16'(rc); r_sin = 16'(rs);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_in_init", 32'(m_busy), 32'(1));
    check("no_write_init", 32'(m_wr), 32'(0));
    @(negedge clock);
    l_rho = 16'($urandom); l_cos = 16'($urandom); l_sin = 16'($urandom);
    r_rho = 16'($urandom); r_cos = 16'($urandom); r_sin = 16'($urandom);
    check("no_write_read", 32'(m_wr), 32'(0));
    @(negedge clock);
    check("first_write_latency", 32'(m_wr), 32'(1));
  endtask

  task automatic run_frame(input int lr, input int lc, input int ls,
                           input int rr, input int rc, input int rs,
                           input bit hsel, input bit bp13, input bit rbp, input bit restart);
    int d0, budget;
    bit bp_used, rs_used;
    d0 = done_count;
    bp_used = 1'b0;
    rs_used = 1'b0;
    launch(lr, lc, ls, rr, rc, rs, hsel);
    budget = 0;
    while (done_count == d0 && budget < 2000) begin
      @(posedge clock); #1;
      budget++;
      start = 1'b0;
      if (rbp) out_full = ($urandom_range(0, 3) == 0);
      if (restart && !rs_used && wr_count == 5) begin
        start = 1'b1;
        rs_used = 1'b1;
      end
      if (bp13 && !bp_used && wr_count == 13) begin
        bp_used = 1'b1;
        out_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge clock);
          check("bp_no_write", 32'(m_wr), 32'(0));
          check("bp_addr_hold", 32'(m_addr), 32'(13));
        end
        out_full = 1'b0;
      end
    end
    out_full = 1'b0;
    start = 1'b0;
    check("frame_finished_in_budget", 32'(budget < 2000), 32'(1));
    check("write_count", 32'(wr_count), 32'(N));
    @(negedge clock);
    check("done_single_pulse", 32'(done_count - d0), 32'(1));
    check("done_low_after", 32'(m_done), 32'(0));
    check("idle_after_frame", 32'(m_busy), 32'(0));
  endtask

  // Starts a frame and pulls reset low once 20 pixels are out.
  task automatic run_abort(input int lr, input int lc, input int ls,
                           input int rr, input int rc, input int rs);
    int d0, budget;
    d0 = done_count;
    launch(lr, lc, ls, rr, rc, rs, 1'b0);
    budget = 0;
    while (wr_count != 20 && budget < 1000) begin
      @(posedge clock); #1;
      budget++;
    end
    check("abort_reached_pixel20", 32'(wr_count), 32'(20));
    reset = 1'b0;
    check("abort_pending_pixels", 32'(exp_q.size()), 32'(N - 20));
    exp_q.delete();
    exp_a_q.delete();
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("abort_no_write", 32'(m_wr), 32'(0));
      check("abort_idle", 32'(m_busy), 32'(0));
      check("abort_addr_zero", 32'(m_addr), 32'(0));
    end
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("abort_no_done", 32'(done_count), 32'(d0));
    check("abort_no_late_writes", 32'(wr_count), 32'(20));
  endtask

  // ---------------- stimulus ----------------
  int cs_tbl[5] = '{0, 16384, -16384, 8192, -8192};

  initial begin
    reset = 1'b0; start = 1'b0; out_full = 1'b0; sel = 1'b0;
    l_rho = '0; l_cos = '0; l_sin = '0; r_rho = '0; r_cos = '0; r_sin = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_addr", 32'(addr0), 32'(0));
    check("reset_wr_en", 32'(wr0), 32'(0));
    check("reset_din", 32'(din0), 32'(0));
    check("reset_busy", 32'(busy0), 32'(0));
    check("reset_done", 32'(done0), 32'(0));
    check("reset_busy_h3", 32'(busy3), 32'(0));
    reset = 1'b1;
    @(negedge clock);

    // Vertical line at x = 3, horizontal line at y = 2.
    run_frame(3, 16384, 0, 2, 0, 16384, 1'b0, 1'b0, 1'b0, 1'b0);
    // Same lines, overlay only from row 3.
    run_frame(3, 16384, 0, 2, 0, 16384, 1'b1, 1'b0, 1'b0, 1'b0);
    // Output FIFO full for ten cycles at pixel 13.
    run_frame(3, 16384, 0, 2, 0, 16384, 1'b0, 1'b1, 1'b0, 1'b0);
    // start re-pulsed mid-frame is ignored.
    run_frame(3, 16384, 0, 2, 0, 16384, 1'b0, 1'b0, 1'b0, 1'b1);
    // Reset at pixel 20, then a full frame from pixel 0.
    run_abort(3, 16384, 0, 2, 0, 16384);
    run_frame(3, 16384, 0, 2, 0, 16384, 1'b0, 1'b0, 1'b0, 1'b0);
    // Lines entirely outside the image.
    run_frame(-100, 16384, 0, 500, 0, 16384, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random lanes, random horizon instance, random back-pressure.
    for (int f = 0; f < 8; f++) begin
      run_frame(int'($urandom_range(0, 16)) - 4, cs_tbl[$urandom_range(0, 4)], cs_tbl[$urandom_range(0, 4)],
                int'($urandom_range(0, 16)) - 4, cs_tbl[$urandom_range(0, 4)], cs_tbl[$urandom_range(0, 4)],
                1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
